round_timer_ctrl: RTL and testbench

ROUND_TIMER_CTRL -- requirements
Module: round_timer_ctrl

---
 rtl/round_ctrl_pkg.sv | 16 +
 rtl/btn_edge_det.sv | 21 ++
 rtl/round_timer_ctrl.sv | 135 +++++++++++++
 tb/tb_round_timer_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/round_ctrl_pkg.sv
// Shared types and constants for the round timer controller: FSM state
// encodings and the score saturation ceiling.
package round_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_END   = 3'd4,
    ST_OVER  = 3'd5
  } state_e;

  localparam logic [6:0] SCORE_MAX = 7'd99;

endpackage

// File: rtl/btn_edge_det.sv
// One-flop rising-edge detector for level-sensitive game buttons; the pulse
// is combinational and is consumed by the next clock edge.
module btn_edge_det (
  input  logic clk_10H,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic btn_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk_10H or negedge reset) begin
    if (!reset) btn_prev <= 1'b0;
    else        btn_prev <= btn;
  end

  assign rise = btn & ~btn_prev;

endmodule

// File: rtl/round_timer_ctrl.sv
// Game round controller: sequences READY/RUN/END phases over NUM_ROUNDS
// rounds, keeps a saturating score. Optional pause via ROUND_TIMER_PAUSE_EN.
module round_timer_ctrl
  import round_ctrl_pkg::*;
#(
  parameter logic [6:0] ROUND_LIMIT = 7'd50,
  parameter int         READY_TICKS = 10,
  parameter int         NUM_ROUNDS  = 3
) (
  input  logic       clk_10H,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       hit,
  input  logic [6:0] timer_count,
  output logic       timer_run,
  output logic [2:0] state_out,
  output logic [3:0] round_num,
  output logic [6:0] score,
  output logic       time_up,
  output logic       game_over
);

  localparam int         CNT_W      = (READY_TICKS > 1) ? $clog2(READY_TICKS) : 1;
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  state_e             state, next_state;
  logic [CNT_W-1:0]   ready_cnt;
  logic               start_edge, pause_edge;
  logic               cnt_load, clr_game, score_inc, round_inc;

  btn_edge_det u_start_edge (
    .clk_10H (clk_10H),
    .reset   (reset),
    .btn     (start),
    .rise    (start_edge)
  );

  btn_edge_det u_pause_edge (
    .clk_10H (clk_10H),
    .reset   (reset),
    .btn     (pause),
    .rise    (pause_edge)
  );

`ifndef ROUND_TIMER_PAUSE_EN
  logic unused_pause_edge;
  assign unused_pause_edge = pause_edge;
`endif

  always_ff @(posedge clk_10H or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    next_state = state;
    cnt_load   = 1'b0;
    clr_game   = 1'b0;
    score_inc  = 1'b0;
    round_inc  = 1'b0;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (start_edge) begin
          next_state = ST_READY;
          cnt_load   = 1'b1;
          clr_game   = 1'b1;
        end
      end
      ST_READY: begin
        if (ready_cnt == '0) next_state = ST_RUN;
      end
      ST_RUN: begin
        // A hit in the same cycle as a timeout or pause still counts.
        score_inc = hit;
        if (timer_count == ROUND_LIMIT) next_state = ST_END;
`ifdef ROUND_TIMER_PAUSE_EN
        else if (pause_edge)            next_state = ST_PAUSE;
`endif
      end
`ifdef ROUND_TIMER_PAUSE_EN
      ST_PAUSE: begin
        if (pause_edge) begin
          next_state = ST_READY;
          cnt_load   = 1'b1;
        end
      end
`endif
      ST_END: begin
        if (round_num == LAST_ROUND) begin
          next_state = ST_OVER;
        end else begin
          next_state = ST_READY;
          cnt_load   = 1'b1;
          round_inc  = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs are registered from next_state so they line up with state_out.
  always_ff @(posedge clk_10H or negedge reset) begin
    if (!reset) begin
      ready_cnt <= '0;
      score     <= '0;
      round_num <= '0;
      timer_run <= 1'b0;
      time_up   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      if (cnt_load)
        ready_cnt <= CNT_W'(READY_TICKS - 1);
      else if (state == ST_READY && ready_cnt != '0)
        ready_cnt <= ready_cnt - CNT_W'(1);

      if (clr_game)
        score <= '0;
      else if (score_inc && score != SCORE_MAX)
        score <= score + 7'd1;

      if (clr_game)       round_num <= '0;
      else if (round_inc) round_num <= round_num + 4'd1;

      timer_run <= (next_state == ST_RUN);
      time_up   <= (next_state == ST_END);
      game_over <= (next_state == ST_OVER);
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Directed self-checking bench for round_timer_ctrl; pause expectations
// follow ROUND_TIMER_PAUSE_EN as defined for the build.
module tb_round_timer_ctrl;

  logic       clk_10H = 1'b0;
  logic       reset   = 1'b0;
  logic       start   = 1'b0;
  logic       pause   = 1'b0;
  logic       hit     = 1'b0;
  logic [6:0] timer_count = 7'd0;
  logic       timer_run;
  logic [2:0] state_out;
  logic [3:0] round_num;
  logic [6:0] score;
  logic       time_up;
  logic       game_over;

  int errors = 0;
  int checks = 0;
  int exp_score;

  localparam int S_IDLE = 0, S_READY = 1, S_RUN = 2, S_PAUSE = 3, S_END = 4, S_OVER = 5;

  round_timer_ctrl dut (
    .clk_10H     (clk_10H),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .hit         (hit),
    .timer_count (timer_count),
    .timer_run   (timer_run),
    .state_out   (state_out),
    .round_num   (round_num),
    .score       (score),
    .time_up     (time_up),
    .game_over   (game_over)
  );

  always #5 clk_10H = ~clk_10H;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_10H);
  endtask

  task automatic press_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  // From the first observed READY cycle, READY_TICKS more edges reach RUN.
  task automatic wait_run(input string tag);
    cyc(10);
    check({tag, "_state"}, int'(state_out), S_RUN);
    check({tag, "_run"}, int'(timer_run), 1);
  endtask

  task automatic hits(input int n);
    hit = 1'b1;
    cyc(n);
    hit = 1'b0;
  endtask

  // Times out the current round, optionally with a hit in the timeout cycle.
  task automatic timeout(input logic with_hit, input int rnd);
    hit = with_hit;
    timer_count = 7'd50;
    cyc(1);
    hit = 1'b0;
    timer_count = 7'd0;
    check("end_state", int'(state_out), S_END);
    check("end_time_up", int'(time_up), 1);
    check("end_run", int'(timer_run), 0);
    check("end_round", int'(round_num), rnd);
  endtask

  initial begin
    // Reset state
    cyc(2);
    check("rst_state", int'(state_out), S_IDLE);
    check("rst_run", int'(timer_run), 0);
    check("rst_score", int'(score), 0);
    check("rst_over", int'(game_over), 0);
    reset = 1'b1;
    cyc(2);
    check("idle_hold", int'(state_out), S_IDLE);

    // Start edge -> READY for 10 cycles with timer held, then RUN
    press_start();
    check("ready_state", int'(state_out), S_READY);
    check("ready_run", int'(timer_run), 0);
    cyc(9);
    check("ready_last", int'(state_out), S_READY);
    check("ready_last_run", int'(timer_run), 0);
    cyc(1);
    check("run_state", int'(state_out), S_RUN);
    check("run_run", int'(timer_run), 1);

    // Round 0
    hits(5);
    check("r0_score", int'(score), 5);
    timeout(1'b0, 0);
    cyc(1);
    check("r0_after_state", int'(state_out), S_READY);
    check("r0_after_time_up", int'(time_up), 0);
    check("r0_after_round", int'(round_num), 1);
    wait_run("r1");

    // Round 1
    hits(5);
    timeout(1'b0, 1);
    cyc(1);
    check("r1_after_round", int'(round_num), 2);
    wait_run("r2");

    // Round 2: last hit coincides with the timeout
    hits(4);
    timeout(1'b1, 2);
    check("r2_score", int'(score), 15);
    cyc(1);
    check("over_state", int'(state_out), S_OVER);
    check("over_flag", int'(game_over), 1);
    check("over_score", int'(score), 15);
    hits(3);
    check("over_frozen", int'(score), 15);
    check("over_stays", int'(state_out), S_OVER);

    // Start edge from OVER begins a new game
    press_start();
    check("restart_state", int'(state_out), S_READY);
    check("restart_score", int'(score), 0);
    check("restart_round", int'(round_num), 0);
    check("restart_over", int'(game_over), 0);
    wait_run("g2");

    // Pause behaviour
    hits(2);
    hit = 1'b1;
    pause = 1'b1;
    cyc(1);
    hit = 1'b0;
    pause = 1'b0;
    check("pause_hit_score", int'(score), 3);
`ifdef ROUND_TIMER_PAUSE_EN
    check("pause_state", int'(state_out), S_PAUSE);
    check("pause_run", int'(timer_run), 0);
    exp_score = 3;
`else
    check("nopause_state", int'(state_out), S_RUN);
    check("nopause_run", int'(timer_run), 1);
    exp_score = 6;
`endif
    hits(3);
    check("pause_hits", int'(score), exp_score);
    start = 1'b1;
    pause = 1'b1;
    cyc(1);
    start = 1'b0;
    pause = 1'b0;
    check("unpause_round", int'(round_num), 0);
    check("unpause_score", int'(score), exp_score);
`ifdef ROUND_TIMER_PAUSE_EN
    check("unpause_state", int'(state_out), S_READY);
    wait_run("resume");
`else
    check("unpause_state", int'(state_out), S_RUN);
`endif

    // Score saturation with timer below the limit
    timer_count = 7'd10;
    hits(98 - exp_score);
    check("sat_98", int'(score), 98);
    hits(120 - (98 - exp_score));
    check("sat_99", int'(score), 99);
    check("sat_state", int'(state_out), S_RUN);
    timer_count = 7'd0;

    // Asynchronous reset from RUN with a full score
    #2 reset = 1'b0;
    #1 check("arst1_state", int'(state_out), S_IDLE);
    check("arst1_score", int'(score), 0);
    check("arst1_run", int'(timer_run), 0);
    cyc(1);
    reset = 1'b1;
    cyc(3);
    check("arst1_idle", int'(state_out), S_IDLE);

    // Mid-RUN reset with score 7, no clock edge in between
    press_start();
    wait_run("g3");
    hits(7);
    check("pre_rst_score", int'(score), 7);
    #2 reset = 1'b0;
    #1 check("arst2_state", int'(state_out), S_IDLE);
    check("arst2_score", int'(score), 0);
    check("arst2_run", int'(timer_run), 0);
    check("arst2_round", int'(round_num), 0);
    check("arst2_time_up", int'(time_up), 0);
    check("arst2_over", int'(game_over), 0);
    cyc(1);
    reset = 1'b1;
    cyc(3);
    check("post_rst_idle", int'(state_out), S_IDLE);
    press_start();
    check("post_rst_ready", int'(state_out), S_READY);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
